keyboard_fifo_wb: RTL and testbench

- Parametrised keyboard register block for the BK bus. It accepts decoded 7-bit key codes from the PS/2 translator and buffers them in a FIFO of configurable depth.
- It exposes the status/data register pair at a configurable base address and raises vectored interrupts (60 or 274) per FIFO entry.
- It adds hardware typematic autorepeat and a sticky overflow flag.
- It sits between the keyboard translator and the bus/VIRQ arbiter.

---
 rtl/keyboard_fifo_wb.sv | 184 ++++++++++++++++++
 tb/tb_keyboard_fifo_wb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_fifo_wb.sv
// Keyboard register block for the BK bus: key-code FIFO, status/data registers,
// vectored interrupt requests and hardware typematic autorepeat.
//
// Autorepeat FSM:
//   state      | meaning
//   RPT_IDLE   | no key held, or autorepeat disabled
//   RPT_DELAY  | counting down the initial delay after a key press
//   RPT_REPEAT | counting down the period between repeats
module keyboard_fifo_wb #(
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] BASE_ADDR     = 16'o177660,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter logic [23:0] REPEAT_DELAY  = 24'd1500000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd300000
) (
    input  logic                          clk_bus,
    input  logic                          bus_reset,
    input  logic [15:0]                   bus_din,
    output logic [15:0]                   bus_dout,
    input  logic [15:0]                   bus_addr,
    input  logic                          bus_sync,
    input  logic                          bus_we,
    input  logic                          bus_stb,
    output logic                          bus_ack,
    input  logic                          key_valid,
    input  logic [6:0]                    key_code,
    input  logic                          key_ar2,
    input  logic                          key_held,
    output logic                          virq_req60,
    input  logic                          virq_ack60,
    output logic                          virq_req274,
    input  logic                          virq_ack274,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd2;
    localparam logic [AW:0] DEPTH_L   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  head;
    logic        fifo_empty, fifo_full;

    logic        ack_q, stb_sel_q, ack60_q, ack274_q;
    logic [15:0] rd_q;
    logic        mask, ovf, irq_done;
    logic [6:0]  data_q;

    logic        sel_st, sel_dt, sel_any, stb_sel, act;
    logic        wr_st, rd_st, pop;
    logic [15:0] status_word, live;

    logic        key_accept, push_req, do_push, drop;
    logic [7:0]  push_entry;

    rpt_state_t  rpt_state, rpt_state_nxt;
    logic [23:0] rpt_cnt, rpt_cnt_nxt;
    logic [7:0]  rpt_entry;
    logic        rpt_tick, rpt_latch;

    logic        unused_bits;
    assign unused_bits = ^{bus_din[15:7], bus_din[5:0], bus_addr[0]};

    assign sel_st  = bus_sync & (bus_addr[15:1] == BASE_ADDR[15:1]);
    assign sel_dt  = bus_sync & (bus_addr[15:1] == DATA_ADDR[15:1]) & ~bus_we;
    assign sel_any = sel_st | sel_dt;
    assign stb_sel = bus_stb & sel_any;
    assign act     = stb_sel & ~stb_sel_q;
    assign wr_st   = act & sel_st & bus_we;
    assign rd_st   = act & sel_st & ~bus_we;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_level == DEPTH_L);
    assign pop        = act & sel_dt & ~fifo_empty;

    assign status_word = {ovf, 7'b0, ~fifo_empty, mask, 6'b0};
    assign live = sel_st ? status_word :
                  sel_dt ? {9'b0, (fifo_empty ? data_q : head[6:0])} : 16'h0000;

    // Hold the value captured at the action edge so side effects (pop, ovf clear)
    // never change what the master sees while it still holds the strobe.
    assign bus_dout = sel_any ? (stb_sel_q ? rd_q : live) : 16'h0000;
    assign bus_ack  = stb_sel & ack_q;

    assign key_accept = key_valid & (key_code != 7'd0);
    assign push_req   = key_valid ? key_accept : rpt_tick;
    assign push_entry = key_valid ? {key_ar2, key_code} : rpt_entry;
    assign do_push    = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    always_ff @(posedge clk_bus) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk_bus or posedge bus_reset) begin
        if (bus_reset) begin
            ack_q       <= 1'b0;
            stb_sel_q   <= 1'b0;
            ack60_q     <= 1'b0;
            ack274_q    <= 1'b0;
            rd_q        <= 16'h0000;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_q      <= 7'd0;
            mask        <= 1'b1;
            ovf         <= 1'b0;
            irq_done    <= 1'b0;
            virq_req60  <= 1'b0;
            virq_req274 <= 1'b0;
        end else begin
            ack_q     <= bus_stb;
            stb_sel_q <= stb_sel;
            ack60_q   <= virq_ack60;
            ack274_q  <= virq_ack274;
            if (act) rd_q <= live;
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                data_q <= head[6:0];
            end
            if (wr_st) mask <= bus_din[6];
            if (rd_st) ovf <= 1'b0;
            if (drop) ovf <= 1'b1;

            // irq_done stops an acknowledged head entry from re-requesting until popped
            if (pop || (wr_st && bus_din[6])) begin
                virq_req60  <= 1'b0;
                virq_req274 <= 1'b0;
                if (pop) irq_done <= 1'b0;
            end else if (virq_req60 && virq_ack60 && !ack60_q) begin
                virq_req60 <= 1'b0;
                irq_done   <= 1'b1;
            end else if (virq_req274 && virq_ack274 && !ack274_q) begin
                virq_req274 <= 1'b0;
                irq_done    <= 1'b1;
            end else if (!mask && !fifo_empty && !virq_req60 && !virq_req274 && !irq_done) begin
                if (head[7]) virq_req274 <= 1'b1;
                else         virq_req60  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_bus or posedge bus_reset) begin
        if (bus_reset) begin
            rpt_state <= RPT_IDLE;
            rpt_cnt   <= 24'd0;
            rpt_entry <= 8'h00;
        end else begin
            rpt_state <= rpt_state_nxt;
            rpt_cnt   <= rpt_cnt_nxt;
            if (rpt_latch) rpt_entry <= {key_ar2, key_code};
        end
    end

    always_comb begin
        rpt_state_nxt = rpt_state;
        rpt_cnt_nxt   = rpt_cnt;
        rpt_tick      = 1'b0;
        rpt_latch     = 1'b0;
        if (!REPEAT_EN) begin
            rpt_state_nxt = RPT_IDLE;
        end else if (key_accept) begin
            rpt_latch     = 1'b1;
            rpt_cnt_nxt   = REPEAT_DELAY - 24'd1;
            rpt_state_nxt = RPT_DELAY;
        end else if (!key_held) begin
            rpt_state_nxt = RPT_IDLE;
        end else if (rpt_state != RPT_IDLE) begin
            if (rpt_cnt == 24'd0) begin
                rpt_tick      = 1'b1;
                rpt_cnt_nxt   = REPEAT_PERIOD - 24'd1;
                rpt_state_nxt = RPT_REPEAT;
            end else begin
                rpt_cnt_nxt = rpt_cnt - 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_fifo_wb.sv
// Directed bench for keyboard_fifo_wb: register-access vector table plus
// hand-written sequences for interrupts, autorepeat, full-FIFO pop and reset.
module tb_keyboard_fifo_wb;

    localparam logic [15:0] BASE = 16'o177660;
    localparam logic [15:0] DATA = 16'o177662;

    logic        clk_bus = 1'b0;
    logic        bus_reset = 1'b1;
    logic [15:0] bus_din = '0, bus_addr = '0;
    logic [15:0] bus_dout;
    logic        bus_sync = 1'b0, bus_we = 1'b0, bus_stb = 1'b0;
    logic        bus_ack;
    logic        key_valid = 1'b0, key_ar2 = 1'b0, key_held = 1'b0;
    logic [6:0]  key_code = '0;
    logic        virq_req60, virq_req274;
    logic        virq_ack60 = 1'b0, virq_ack274 = 1'b0;
    logic [3:0]  fifo_level;

    int chk_cnt = 0;
    int pass_cnt = 0;

    keyboard_fifo_wb #(
        .FIFO_DEPTH(8), .BASE_ADDR(BASE), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd4)
    ) dut (
        .clk_bus(clk_bus), .bus_reset(bus_reset), .bus_din(bus_din), .bus_dout(bus_dout),
        .bus_addr(bus_addr), .bus_sync(bus_sync), .bus_we(bus_we), .bus_stb(bus_stb),
        .bus_ack(bus_ack), .key_valid(key_valid), .key_code(key_code), .key_ar2(key_ar2),
        .key_held(key_held), .virq_req60(virq_req60), .virq_ack60(virq_ack60),
        .virq_req274(virq_req274), .virq_ack274(virq_ack274), .fifo_level(fifo_level)
    );

    always #5 clk_bus = ~clk_bus;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_dout;
        logic        exp_ack;
        logic [3:0]  exp_level;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        bus_sync = 0; bus_stb = 0; bus_we = 0; key_valid = 0; key_held = 0;
        virq_ack60 = 0; virq_ack274 = 0;
        bus_reset = 1;
        repeat (2) @(negedge clk_bus);
        bus_reset = 0;
        @(negedge clk_bus);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d, output logic ack);
        @(negedge clk_bus);
        bus_sync = 1; bus_addr = a; bus_we = 0; bus_stb = 1;
        @(negedge clk_bus);
        d = bus_dout; ack = bus_ack;
        bus_stb = 0; bus_sync = 0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] wd, output logic ack);
        @(negedge clk_bus);
        bus_sync = 1; bus_addr = a; bus_we = 1; bus_din = wd; bus_stb = 1;
        @(negedge clk_bus);
        ack = bus_ack;
        bus_stb = 0; bus_sync = 0; bus_we = 0;
    endtask

    task automatic push_key(input logic [6:0] c, input logic a2);
        @(negedge clk_bus);
        key_valid = 1; key_code = c; key_ar2 = a2;
        @(negedge clk_bus);
        key_valid = 0;
    endtask

    initial begin
        logic [15:0] d;
        logic        ak;

        // Register-access table, applied after 'A'..'I' are pushed into a depth-8 FIFO
        vecs[0]  = '{1'b0, BASE, 16'h0, 16'h80C0, 1'b1, 4'd8};
        vecs[1]  = '{1'b0, BASE, 16'h0, 16'h00C0, 1'b1, 4'd8};
        for (int i = 0; i < 8; i++)
            vecs[2+i] = '{1'b0, DATA, 16'h0, 16'h0041 + 16'(i), 1'b1, 4'(7 - i)};
        vecs[10] = '{1'b0, DATA, 16'h0, 16'h0048, 1'b1, 4'd0};
        vecs[11] = '{1'b0, BASE, 16'h0, 16'h0040, 1'b1, 4'd0};
        vecs[12] = '{1'b0, 16'o177664, 16'h0, 16'h0000, 1'b0, 4'd0};

        // Reset state and first interrupt
        do_reset();
        check("rst level", 32'(fifo_level), 32'd0);
        check("rst req60", 32'(virq_req60), 32'd0);
        check("rst req274", 32'(virq_req274), 32'd0);
        check("rst ack", 32'(bus_ack), 32'd0);
        check("rst dout", 32'(bus_dout), 32'd0);
        bus_rd(DATA, d, ak);
        check("empty data", 32'(d), 32'h0000);
        bus_wr(BASE, 16'h0000, ak);
        check("mask wr ack", 32'(ak), 32'd1);
        push_key(7'h41, 1'b0);
        repeat (2) @(negedge clk_bus);
        check("t1 req60", 32'(virq_req60), 32'd1);
        check("t1 req274", 32'(virq_req274), 32'd0);
        bus_rd(BASE, d, ak);
        check("t1 status", 32'(d), 32'h0080);
        bus_rd(DATA, d, ak);
        check("t1 data", 32'(d), 32'h0041);
        check("t1 req60 clr", 32'(virq_req60), 32'd0);
        check("t1 level", 32'(fifo_level), 32'd0);
        @(negedge clk_bus);
        check("t1 req60 stays", 32'(virq_req60), 32'd0);

        // Overflow and table-driven reads
        do_reset();
        for (int i = 0; i < 9; i++) push_key(7'h41 + 7'(i), 1'b0);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].we) bus_wr(vecs[i].addr, vecs[i].wdata, ak);
            else            bus_rd(vecs[i].addr, d, ak);
            if (!vecs[i].we) check($sformatf("row%0d dout", i), 32'(d), 32'(vecs[i].exp_dout));
            check($sformatf("row%0d ack", i), 32'(ak), 32'(vecs[i].exp_ack));
            check($sformatf("row%0d level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
        end

        // Vectored interrupts with ack edge
        do_reset();
        bus_wr(BASE, 16'h0000, ak);
        push_key(7'h61, 1'b1);
        push_key(7'h62, 1'b0);
        repeat (2) @(negedge clk_bus);
        check("t3 req274", 32'(virq_req274), 32'd1);
        check("t3 req60", 32'(virq_req60), 32'd0);
        virq_ack274 = 1;
        @(negedge clk_bus);
        check("t3 ack clr", 32'(virq_req274), 32'd0);
        virq_ack274 = 0;
        repeat (3) @(negedge clk_bus);
        check("t3 no rereq274", 32'(virq_req274), 32'd0);
        check("t3 no req60", 32'(virq_req60), 32'd0);
        bus_rd(DATA, d, ak);
        check("t3 data", 32'(d), 32'h0061);
        check("t3 req60 lag", 32'(virq_req60), 32'd0);
        @(negedge clk_bus);
        check("t3 req60 next", 32'(virq_req60), 32'd1);

        // Autorepeat: ticks 10,14,18,22 cycles after accept
        do_reset();
        @(negedge clk_bus);
        key_valid = 1; key_code = 7'h58; key_ar2 = 0; key_held = 1;
        @(negedge clk_bus);
        key_valid = 0;
        check("rpt k0", 32'(fifo_level), 32'd1);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk_bus);
            if (k == 9)  check("rpt k9", 32'(fifo_level), 32'd1);
            if (k == 10) check("rpt k10", 32'(fifo_level), 32'd2);
            if (k == 24) check("rpt k24", 32'(fifo_level), 32'd5);
        end
        key_held = 0;
        repeat (20) @(negedge clk_bus);
        check("rpt stopped", 32'(fifo_level), 32'd5);
        bus_rd(DATA, d, ak);
        check("rpt data", 32'(d), 32'h0058);

        // Full FIFO: pop coincident with push, then async reset mid-cycle
        do_reset();
        for (int i = 0; i < 8; i++) push_key(7'h41 + 7'(i), 1'b0);
        @(negedge clk_bus);
        bus_sync = 1; bus_addr = DATA; bus_we = 0; bus_stb = 1;
        key_valid = 1; key_code = 7'h5A; key_ar2 = 0;
        @(negedge clk_bus);
        key_valid = 0;
        check("t5 pop data", 32'(bus_dout), 32'h0041);
        check("t5 level", 32'(fifo_level), 32'd8);
        bus_stb = 0; bus_sync = 0;
        bus_rd(BASE, d, ak);
        check("t5 no ovf", 32'(d), 32'h00C0);
        bus_wr(BASE, 16'h0000, ak);
        @(negedge clk_bus);
        bus_sync = 1; bus_addr = BASE; bus_we = 0; bus_stb = 1;
        @(posedge clk_bus);
        #2;
        check("t5 pre req60", 32'(virq_req60), 32'd1);
        check("t5 pre ack", 32'(bus_ack), 32'd1);
        bus_reset = 1;
        #1;
        check("t5 async level", 32'(fifo_level), 32'd0);
        check("t5 async req60", 32'(virq_req60), 32'd0);
        check("t5 async req274", 32'(virq_req274), 32'd0);
        check("t5 async ack", 32'(bus_ack), 32'd0);
        check("t5 async dout", 32'(bus_dout), 32'h0040);
        @(negedge clk_bus);
        bus_stb = 0; bus_sync = 0; bus_reset = 0;

        // Write to data register is not selected
        do_reset();
        push_key(7'h4B, 1'b0);
        push_key(7'h4C, 1'b0);
        @(negedge clk_bus);
        bus_sync = 1; bus_addr = DATA; bus_we = 1; bus_din = 16'h00FF; bus_stb = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_bus);
            check($sformatf("t6 wr ack c%0d", c), 32'(bus_ack), 32'd0);
        end
        bus_stb = 0; bus_sync = 0; bus_we = 0;
        check("t6 level", 32'(fifo_level), 32'd2);
        bus_rd(DATA, d, ak);
        check("t6 head", 32'(d), 32'h004B);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
